uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one uart_tx serializer between NUM_REQ byte-producing requesters.
- Accepts one byte per grant over a valid/ready handshake and drives the serializer's din and send inputs.
- Waits for the serializer's done pulse, or a watchdog timeout, before the next grant.
- Sits between command/telemetry sources and the UART pin driver.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- TIMEOUT, 64, max cycles from tx_send to tx_done before abort (must exceed the serializer frame time, 12 cycles).
- GAP_CYCLES, 1, idle cycles inserted after each frame before re-arbitration (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-port byte available; held until accepted.
- req_data  in  8*NUM_REQ  port i byte at [8i+7:8i].
- req_last  in  NUM_REQ  last byte of packet; used only with ARB_PKT_LOCK_EN.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- tx_din  out  8  byte to serializer.
- tx_send  out  1  one-cycle start pulse to serializer.
- tx_done  in  1  serializer frame-complete pulse.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  clog2(NUM_REQ)  index of last/current granted port.
- err_timeout  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset values:
  - req_ready=0, tx_send=0, tx_din=8'hFF, busy=0, err_timeout=0.
  - grant_id=0, state=IDLE.
  - Internal round-robin pointer = NUM_REQ-1, so port 0 wins first.
- Reset mid-frame returns to IDLE immediately. No byte is re-sent.
- All outputs are registered.
- States: IDLE, WAIT, GAP.
- IDLE:
  - At an edge where any req_valid=1, pick the first set bit searching upward (wrapping) from pointer+1.
  - In the following cycle, req_ready[g]=1 and tx_send=1 together for exactly one cycle.
  - tx_din=req_data[g] is latched at the same edge and held stable until the next grant.
  - pointer=g, grant_id=g, watchdog counter cleared, next state WAIT.
  - With no valid requesters: stay in IDLE, all pulses 0.
- Latency: valid sampled at edge k, then ready/send high during cycle k+1. Minimum of 1 cycle.
- WAIT:
  - Counter increments each cycle.
  - tx_done=1 moves to GAP.
  - Counter reaching TIMEOUT-1 without tx_done gives err_timeout=1 for one cycle and moves to GAP.
  - If tx_done and timeout coincide, tx_done wins and err_timeout stays 0.
- GAP: hold for GAP_CYCLES cycles, then IDLE. tx_done arriving in GAP or IDLE is ignored.
- Requester rules:
  - Dropping valid before ready is allowed; that port is simply not granted.
  - Data is sampled only at the grant edge.
- Fairness: a port that is continuously valid waits at most NUM_REQ-1 frames.

Optional Feature:
- Macro: ARB_PKT_LOCK_EN.
- Defined:
  - After granting port g with req_last[g]=0, the next arbitration grants g only, waiting in IDLE for its valid.
  - Lock releases after a byte accepted with req_last=1, or on err_timeout, or on reset.
  - The pointer advances only on release.
- Undefined: req_last is ignored; every byte is arbitrated independently.

Decomposition:
- Shared package uart_pkg:
  - State encoding localparams IDLE/WAIT/GAP.
  - UART_IDLE_BYTE=8'hFF.
  - FRAME_BITS=10.
  - Function clog2_safe.
- One natural sub-module: rr_pick, a combinational round-robin priority selector (req vector, pointer -> one-hot grant, index, any).

Test Plan:
- Single request: port 2 valid with 8'hA5, TX model returns done 11 cycles after send.
  -> req_ready=4'b0100 and tx_send pulse in the same cycle, tx_din=8'hA5, busy for 13 cycles, grant_id=2.
- Fairness: all 4 ports valid continuously with data 8'h10+i.
  -> bytes sent in order 10,11,12,13,10; no port is skipped.
- Timeout: TX model never asserts done.
  -> err_timeout pulses exactly 64 cycles after tx_send, then GAP, then next grant proceeds.
- Coincidence: tx_done asserted in the cycle counter=TIMEOUT-1.
  -> err_timeout stays 0, normal GAP.
- Reset mid-WAIT: rst asserted 5 cycles after send.
  -> all outputs at reset values in the same cycle; after release, port 0 is granted first.
- ARB_PKT_LOCK_EN: port 1 sends 3 bytes (last on the third) while port 0 is valid.
  -> three consecutive port-1 grants, then port 0; without the macro, grants alternate 1,0,1.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, UART constants and width helper
//
// Purpose : common definitions for the uart_tx_arbiter block.
// Contents: state_t with IDLE/WAIT/GAP, UART_IDLE_BYTE, FRAME_BITS,
//           clog2_safe() which never returns less than 1 bit.
package uart_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t WAIT = 2'd1;
   localparam state_t GAP  = 2'd2;

   // Line level while no frame is on the wire.
   localparam logic [7:0] UART_IDLE_BYTE = 8'hFF;

   // Start + 8 data + stop.
   localparam int FRAME_BITS = 10;

   // Ceiling log2 clamped to 1 so a width derived from it is never zero.
   function automatic int clog2_safe(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin priority selector
//
// Purpose : returns the first asserted request found searching upward
//           (wrapping) from ptr+1, so the port at ptr has lowest priority.
// Ports   : req  [N]  request vector
//           ptr  [IW] index of the previous winner
//           gnt  [N]  one-hot winner (zero when no request)
//           idx  [IW] winner index (zero when no request)
//           any       at least one request asserted
module rr_pick
   import uart_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2_safe(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] j;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = '0;
      // i runs 1..N so the previous winner (offset N) is visited last.
      for (int i = 1; i <= N; i++) begin
         j = IW'((int'(ptr) + i) % N);
         if (!any && req[j]) begin
            any    = 1'b1;
            idx    = j;
            gnt[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_tx serializer
//
// Purpose : grants one byte per frame to NUM_REQ requesters, pulses the
//           serializer start, then waits for tx_done (or a watchdog abort)
//           plus GAP_CYCLES idle cycles before arbitrating again.
// Ports   : clk, rst (async, active high)
//           req_valid/req_data/req_last  per-port byte offer
//           req_ready                    one-hot one-cycle accept pulse
//           tx_din/tx_send/tx_done       serializer interface
//           busy, grant_id, err_timeout  status
// Options : define ARB_PKT_LOCK_EN to keep a grant on one port until it
//           delivers a byte flagged req_last (or the watchdog fires).
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int TIMEOUT    = 64,
   parameter int GAP_CYCLES = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [8*NUM_REQ-1:0]               req_data,
   input  logic [NUM_REQ-1:0]                 req_last,
   output logic [NUM_REQ-1:0]                 req_ready,
   output logic [7:0]                         tx_din,
   output logic                               tx_send,
   input  logic                               tx_done,
   output logic                               busy,
   output logic [clog2_safe(NUM_REQ)-1:0]     grant_id,
   output logic                               err_timeout
);

   localparam int IW = clog2_safe(NUM_REQ);
   localparam int CW = clog2_safe(TIMEOUT);
   localparam int GW = clog2_safe(GAP_CYCLES);

   state_t               state;
   state_t               state_nxt;
   logic [IW-1:0]        ptr;
   logic [CW-1:0]        wd_cnt;
   logic [GW-1:0]        gap_cnt;

   logic [NUM_REQ-1:0]   pick_req;
   logic [NUM_REQ-1:0]   pick_gnt;
   logic [IW-1:0]        pick_idx;
   logic                 pick_any;

   logic                 timeout_hit;
   logic [NUM_REQ-1:0]   ready_nxt;
   logic                 send_nxt;
   logic                 busy_nxt;
   logic                 err_nxt;

   logic                 ptr_load;
   logic [IW-1:0]        ptr_val;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr_pick (
      .req (pick_req),
      .ptr (ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // tx_done has priority over the watchdog when both land on the same edge.
   assign timeout_hit = (state == WAIT) && !tx_done && (wd_cnt == CW'(TIMEOUT - 1));

`ifdef ARB_PKT_LOCK_EN
   logic          lock;
   logic [IW-1:0] lock_id;

   // While locked only the owning port can win; the pointer stays put so
   // the packet owner keeps its place in the rotation until release.
   always_comb begin
      pick_req = lock ? (req_valid & (NUM_REQ'(1) << lock_id)) : req_valid;
   end

   always_comb begin
      ptr_load = 1'b0;
      ptr_val  = pick_idx;
      if (send_nxt && req_last[pick_idx]) begin
         ptr_load = 1'b1;
      end else if (timeout_hit && lock) begin
         ptr_load = 1'b1;
         ptr_val  = grant_id;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock    <= 1'b0;
         lock_id <= '0;
      end else if (send_nxt) begin
         lock    <= !req_last[pick_idx];
         lock_id <= pick_idx;
      end else if (timeout_hit) begin
         lock    <= 1'b0;
      end
   end
`else
   logic unused_last;
   assign unused_last = ^req_last;

   always_comb begin
      pick_req = req_valid;
      ptr_load = send_nxt;
      ptr_val  = pick_idx;
   end
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (pick_any) state_nxt = WAIT;
         WAIT: if (tx_done || (wd_cnt == CW'(TIMEOUT - 1))) state_nxt = GAP;
         GAP:  if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs.
   always_comb begin
      ready_nxt = '0;
      send_nxt  = 1'b0;
      busy_nxt  = (state_nxt != IDLE);
      err_nxt   = timeout_hit;
      if ((state == IDLE) && pick_any) begin
         ready_nxt = pick_gnt;
         send_nxt  = 1'b1;
      end
   end

   // Registered outputs and datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready   <= '0;
         tx_send     <= 1'b0;
         tx_din      <= UART_IDLE_BYTE;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
         grant_id    <= '0;
         ptr         <= IW'(NUM_REQ - 1);
         wd_cnt      <= '0;
         gap_cnt     <= '0;
      end else begin
         req_ready   <= ready_nxt;
         tx_send     <= send_nxt;
         busy        <= busy_nxt;
         err_timeout <= err_nxt;
         if (send_nxt) begin
            tx_din   <= req_data[8*pick_idx +: 8];
            grant_id <= pick_idx;
         end
         if (ptr_load) begin
            ptr <= ptr_val;
         end
         // Both counters idle at zero so each visit starts from a clean count.
         wd_cnt  <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
         gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      end
   end

endmodule
